// File: rtl/nn_dense_engine.sv
// ---------------------------------------------------------------------------
// nn_dense_engine
//
// Fully-connected (dense) layer engine. For each output neuron o it walks the
// input vector one bus word at a time, fetching the matching input word and
// weight word. It multiplies LANES signed element pairs per word and sums them
// into a wrapping accumulator. The accumulator is then shifted, optionally
// ReLU'd and saturated, and the result is written out one element per
// handshake.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 launch pulse (sampled in IDLE only)
//   operation_type        0 = dense, 1 = dense + ReLU, other = invalid
//   irq_clear             clears the sticky interrupt
//   in_words              input vector length in bus words
//   out_count             number of output neurons
//   shift                 arithmetic right shift applied before saturation
//   input/weight/output_base  word-granular base addresses
//   done                  one-cycle completion pulse
//   busy                  high in every state except IDLE
//   error                 invalid operation_type seen at launch
//   cycle_count           busy cycles of the last job (saturating)
//   operation_count       multiplies performed by the last job
//   interrupt             sticky completion flag
//   input_*  / weight_*   read request channels (valid/ready)
//   output_*              write channel (valid/ready)
// ---------------------------------------------------------------------------
module nn_dense_engine #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [7:0]                    operation_type,
   input  logic                          irq_clear,
   input  logic [15:0]                   in_words,
   input  logic [15:0]                   out_count,
   input  logic [4:0]                    shift,
   input  logic [31:0]                   input_base,
   input  logic [31:0]                   weight_base,
   input  logic [31:0]                   output_base,
   output logic                          done,
   output logic                          busy,
   output logic                          error,
   output logic [31:0]                   cycle_count,
   output logic [31:0]                   operation_count,
   output logic                          interrupt,
   output logic [31:0]                   input_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   input_data,
   output logic                          input_valid,
   input  logic                          input_ready,
   output logic [31:0]                   weight_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   weight_data,
   output logic                          weight_valid,
   input  logic                          weight_ready,
   output logic [31:0]                   output_addr,
   output logic [DATA_WIDTH-1:0]         output_data,
   output logic                          output_valid,
   input  logic                          output_ready
);

   localparam int BUS_W  = LANES * DATA_WIDTH;
   localparam int PROD_W = 2 * DATA_WIDTH;

   // Saturation bounds of a signed DATA_WIDTH value, expressed at accumulator width.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MAC,
      POST,
      WRITE,
      FINISH
   } state_t;

   state_t                      state;

   // Configuration latched at launch so the caller may change inputs mid-job.
   logic                        cfg_relu;
   logic [15:0]                 cfg_words;
   logic [15:0]                 cfg_outs;
   logic [4:0]                  cfg_shift;
   logic [31:0]                 cfg_ibase;
   logic [31:0]                 cfg_wbase;
   logic [31:0]                 cfg_obase;

   logic [15:0]                 k_idx;     // word index within the input vector
   logic [15:0]                 o_idx;     // output neuron index
   logic [31:0]                 w_row;     // o_idx * cfg_words, kept incrementally
   logic signed [ACC_WIDTH-1:0] acc;
   logic [BUS_W-1:0]            in_buf;
   logic [BUS_W-1:0]            wt_buf;
   logic                        in_got;
   logic                        wt_got;

   logic                        in_fire;
   logic                        wt_fire;
   logic signed [ACC_WIDTH-1:0] lane_sum;
   logic signed [ACC_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0]       post_val;

   assign in_fire = input_valid  && input_ready;
   assign wt_fire = weight_valid && weight_ready;

   // Sum of the LANES signed products of the captured words. Each product is
   // formed at full 2*DATA_WIDTH precision and sign-extended before summing.
   always_comb begin
      // NOTE: every combinational output gets a default before any conditional
      // or loop update, so no path leaves it unassigned and no latch is inferred.
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + ACC_WIDTH'(
            PROD_W'($signed(in_buf[i*DATA_WIDTH +: DATA_WIDTH])) *
            PROD_W'($signed(wt_buf[i*DATA_WIDTH +: DATA_WIDTH])));
      end
   end

   // Post-processing: arithmetic shift, optional ReLU, then signed saturation.
   always_comb begin
      shifted = acc >>> cfg_shift;
      if (cfg_relu && shifted[ACC_WIDTH-1]) begin
         shifted = '0;
      end
      if (shifted > SAT_MAX) begin
         post_val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         post_val = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         post_val = shifted[DATA_WIDTH-1:0];
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; later assignments in the same block override
   // earlier ones, which gives interrupt-set priority over irq_clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the operand buffers and accumulator are ordinary registers,
         // not RAM, so they are cleared with everything else on reset.
         state           <= IDLE;
         done            <= 1'b0;
         busy            <= 1'b0;
         error           <= 1'b0;
         cycle_count     <= '0;
         operation_count <= '0;
         interrupt       <= 1'b0;
         input_addr      <= '0;
         input_valid     <= 1'b0;
         weight_addr     <= '0;
         weight_valid    <= 1'b0;
         output_addr     <= '0;
         output_data     <= '0;
         output_valid    <= 1'b0;
         cfg_relu        <= 1'b0;
         cfg_words       <= '0;
         cfg_outs        <= '0;
         cfg_shift       <= '0;
         cfg_ibase       <= '0;
         cfg_wbase       <= '0;
         cfg_obase       <= '0;
         k_idx           <= '0;
         o_idx           <= '0;
         w_row           <= '0;
         acc             <= '0;
         in_buf          <= '0;
         wt_buf          <= '0;
         in_got          <= 1'b0;
         wt_got          <= 1'b0;
      end else begin
         if (irq_clear) begin
            interrupt <= 1'b0;
         end
         if (state != IDLE && cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  cfg_relu        <= (operation_type == 8'd1);
                  cfg_words       <= in_words;
                  cfg_outs        <= out_count;
                  cfg_shift       <= shift;
                  cfg_ibase       <= input_base;
                  cfg_wbase       <= weight_base;
                  cfg_obase       <= output_base;
                  cycle_count     <= '0;
                  operation_count <= '0;
                  error           <= 1'b0;
                  busy            <= 1'b1;
                  acc             <= '0;
                  k_idx           <= '0;
                  o_idx           <= '0;
                  w_row           <= '0;
                  if (operation_type > 8'd1) begin
                     error     <= 1'b1;
                     done      <= 1'b1;
                     interrupt <= 1'b1;
                     state     <= FINISH;
                  end else if (in_words == 16'd0 || out_count == 16'd0) begin
                     done      <= 1'b1;
                     interrupt <= 1'b1;
                     state     <= FINISH;
                  end else begin
                     input_addr   <= input_base;
                     weight_addr  <= weight_base;
                     input_valid  <= 1'b1;
                     weight_valid <= 1'b1;
                     in_got       <= 1'b0;
                     wt_got       <= 1'b0;
                     state        <= FETCH;
                  end
               end
            end

            // The two reads complete independently; leave once both have landed.
            FETCH: begin
               if (in_fire) begin
                  in_buf      <= input_data;
                  input_valid <= 1'b0;
                  in_got      <= 1'b1;
               end
               if (wt_fire) begin
                  wt_buf       <= weight_data;
                  weight_valid <= 1'b0;
                  wt_got       <= 1'b1;
               end
               if ((in_got || in_fire) && (wt_got || wt_fire)) begin
                  state <= MAC;
               end
            end

            MAC: begin
               acc             <= acc + lane_sum;
               operation_count <= operation_count + 32'(LANES);
               if (k_idx + 16'd1 != cfg_words) begin
                  k_idx        <= k_idx + 16'd1;
                  input_addr   <= cfg_ibase + 32'(k_idx) + 32'd1;
                  weight_addr  <= cfg_wbase + w_row + 32'(k_idx) + 32'd1;
                  input_valid  <= 1'b1;
                  weight_valid <= 1'b1;
                  in_got       <= 1'b0;
                  wt_got       <= 1'b0;
                  state        <= FETCH;
               end else begin
                  state <= POST;
               end
            end

            POST: begin
               output_data  <= post_val;
               output_addr  <= cfg_obase + 32'(o_idx);
               output_valid <= 1'b1;
               state        <= WRITE;
            end

            WRITE: begin
               if (output_ready) begin
                  output_valid <= 1'b0;
                  acc          <= '0;
                  if (o_idx + 16'd1 != cfg_outs) begin
                     o_idx        <= o_idx + 16'd1;
                     k_idx        <= '0;
                     w_row        <= w_row + 32'(cfg_words);
                     input_addr   <= cfg_ibase;
                     weight_addr  <= cfg_wbase + w_row + 32'(cfg_words);
                     input_valid  <= 1'b1;
                     weight_valid <= 1'b1;
                     in_got       <= 1'b0;
                     wt_got       <= 1'b0;
                     state        <= FETCH;
                  end else begin
                     done      <= 1'b1;
                     interrupt <= 1'b1;
                     state     <= FINISH;
                  end
               end
            end

            // done was raised on entry; re-asserting interrupt here makes a
            // coinciding irq_clear lose.
            FINISH: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               interrupt <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_dense_engine.sv
// ---------------------------------------------------------------------------
// tb_nn_dense_engine
//
// Self-checking bench for nn_dense_engine (LANES=4, DATA_WIDTH=8). Memories
// are modelled as arrays indexed by the low address byte. Expected writes come
// from a reference model and are queued at launch, then popped and compared
// as the engine writes. Each scenario task does its own comparisons.
// ---------------------------------------------------------------------------
module tb_nn_dense_engine;

   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int BW    = LANES * DW;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        operation_type;
   logic              irq_clear;
   logic [15:0]       in_words;
   logic [15:0]       out_count;
   logic [4:0]        shift;
   logic [31:0]       input_base;
   logic [31:0]       weight_base;
   logic [31:0]       output_base;
   logic              done;
   logic              busy;
   logic              error;
   logic [31:0]       cycle_count;
   logic [31:0]       operation_count;
   logic              interrupt;
   logic [31:0]       input_addr;
   logic [BW-1:0]     input_data;
   logic              input_valid;
   logic              input_ready;
   logic [31:0]       weight_addr;
   logic [BW-1:0]     weight_data;
   logic              weight_valid;
   logic              weight_ready;
   logic [31:0]       output_addr;
   logic [DW-1:0]     output_data;
   logic              output_valid;
   logic              output_ready;

   nn_dense_engine #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .operation_type  (operation_type),
      .irq_clear       (irq_clear),
      .in_words        (in_words),
      .out_count       (out_count),
      .shift           (shift),
      .input_base      (input_base),
      .weight_base     (weight_base),
      .output_base     (output_base),
      .done            (done),
      .busy            (busy),
      .error           (error),
      .cycle_count     (cycle_count),
      .operation_count (operation_count),
      .interrupt       (interrupt),
      .input_addr      (input_addr),
      .input_data      (input_data),
      .input_valid     (input_valid),
      .input_ready     (input_ready),
      .weight_addr     (weight_addr),
      .weight_data     (weight_data),
      .weight_valid    (weight_valid),
      .weight_ready    (weight_ready),
      .output_addr     (output_addr),
      .output_data     (output_data),
      .output_valid    (output_valid),
      .output_ready    (output_ready)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] in_mem [256];
   logic [BW-1:0] wt_mem [256];

   assign input_data  = in_mem[input_addr[7:0]];
   assign weight_data = wt_mem[weight_addr[7:0]];

   typedef struct packed {
      logic [31:0]   addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      int          nw;
      int          nout;
      int          sh;
      int          op;
      logic [31:0] ib;
      logic [31:0] wb;
      logic [31:0] ob;
      int          stall_pct;
      int          out_hold;
      int          restart_at;
      int          abort_at;
      bit          irq_at_finish;
   } job_t;

   wr_t           exp_q [$];
   int            checks = 0;
   int            passes = 0;

   // Per-job observations filled in by run_job.
   int            r_cyc;
   int            r_dones;
   int            r_done_at;
   int            r_valids;
   int            r_writes;
   logic [DW-1:0] r_last;

   function automatic job_t mk_job(int nw, int nout, int sh, int op,
                                   logic [31:0] ib, logic [31:0] wb, logic [31:0] ob);
      job_t j;
      j.nw = nw; j.nout = nout; j.sh = sh; j.op = op;
      j.ib = ib; j.wb = wb; j.ob = ob;
      j.stall_pct = 0; j.out_hold = 0; j.restart_at = -1; j.abort_at = -1;
      j.irq_at_finish = 1'b0;
      return j;
   endfunction

   // Reference model of one output neuron.
   function automatic logic [DW-1:0] model_out(job_t j, int o);
      logic signed [31:0] acc;
      logic signed [31:0] s;
      logic [7:0]         ia;
      logic [7:0]         wa;
      logic [BW-1:0]      iw;
      logic [BW-1:0]      ww;
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      acc = 0;
      for (int k = 0; k < j.nw; k++) begin
         ia = 8'(j.ib + 32'(k));
         wa = 8'(j.wb + 32'(o * j.nw + k));
         iw = in_mem[ia];
         ww = wt_mem[wa];
         for (int i = 0; i < LANES; i++) begin
            a = iw[i*DW +: DW];
            b = ww[i*DW +: DW];
            acc = acc + 32'(a) * 32'(b);
         end
      end
      s = acc >>> j.sh;
      if (j.op == 1 && s < 0) s = 0;
      if (s > 127) return 8'h7F;
      if (s < -128) return 8'h80;
      return s[7:0];
   endfunction

   // Launches one job (caller is at a negedge) and watches it to completion.
   task automatic run_job(input job_t j);
      int          in_hs;
      int          wt_hs;
      int          out_wait;
      bit          seen_done;
      bit          fin;
      bit          aborted;
      logic        pv_i, pr_i, pv_w, pr_w, pv_o, pr_o;
      logic [31:0] pa_i, pa_w, pa_o;
      logic [DW-1:0] pd_o;
      wr_t         e;

      r_cyc = 0; r_dones = 0; r_done_at = -1; r_valids = 0; r_writes = 0; r_last = '0;
      in_hs = 0; wt_hs = 0; out_wait = 0; seen_done = 0; fin = 0; aborted = 0;
      pv_i = 0; pr_i = 0; pv_w = 0; pr_w = 0; pv_o = 0; pr_o = 0;
      pa_i = '0; pa_w = '0; pa_o = '0; pd_o = '0;

      if (j.op <= 1 && j.nw > 0 && j.nout > 0) begin
         for (int o = 0; o < j.nout; o++) begin
            e.addr = j.ob + 32'(o);
            e.data = model_out(j, o);
            exp_q.push_back(e);
         end
      end

      operation_type = 8'(j.op);
      in_words       = 16'(j.nw);
      out_count      = 16'(j.nout);
      shift          = 5'(j.sh);
      input_base     = j.ib;
      weight_base    = j.wb;
      output_base    = j.ob;
      input_ready    = 1'b1;
      weight_ready   = 1'b1;
      output_ready   = (j.out_hold == 0);
      start          = 1'b1;
      @(negedge clk);
      start = 1'b0;

      for (int n = 0; n < 2000; n++) begin
         if (seen_done && !busy) begin
            fin = 1;
            break;
         end
         if (j.abort_at >= 0 && r_writes == j.abort_at && input_valid) begin
            reset = 1'b1;
            #1;
            checks++;
            if ({done, busy, error, cycle_count, operation_count, interrupt, input_addr,
                 input_valid, weight_addr, weight_valid, output_addr, output_data,
                 output_valid} !== '0)
               $display("FAIL reset_mid_zero: outputs not all zero, busy=%b in_valid=%b in_addr=%h cyc=%0d",
                        busy, input_valid, input_addr, cycle_count);
            else passes++;
            exp_q.delete();
            aborted = 1;
            fin = 1;
            break;
         end
         if (busy) r_cyc++;
         if (done) begin
            r_dones++;
            if (r_done_at < 0) r_done_at = r_cyc;
            seen_done = 1;
         end
         if (input_valid || weight_valid || output_valid) r_valids++;

         // Requests left pending last cycle must still be up, unchanged.
         if (pv_i && !pr_i) begin
            checks++;
            if (input_valid !== 1'b1 || input_addr !== pa_i)
               $display("FAIL input_hold: valid=%b addr=%h, need valid=1 addr=%h", input_valid, input_addr, pa_i);
            else passes++;
         end
         if (pv_w && !pr_w) begin
            checks++;
            if (weight_valid !== 1'b1 || weight_addr !== pa_w)
               $display("FAIL weight_hold: valid=%b addr=%h, need valid=1 addr=%h", weight_valid, weight_addr, pa_w);
            else passes++;
         end
         if (pv_o && !pr_o) begin
            checks++;
            if (output_valid !== 1'b1 || output_addr !== pa_o || output_data !== pd_o)
               $display("FAIL output_hold: valid=%b addr=%h data=%h, need valid=1 addr=%h data=%h",
                        output_valid, output_addr, output_data, pa_o, pd_o);
            else passes++;
         end

         start     = (n == j.restart_at);
         if (n == j.restart_at) operation_type = 8'd7;
         irq_clear = j.irq_at_finish && done;

         input_ready  = ($urandom_range(0, 99) >= 32'(j.stall_pct));
         weight_ready = ($urandom_range(0, 99) >= 32'(j.stall_pct));
         if (output_valid) begin
            output_ready = (out_wait >= j.out_hold);
            out_wait++;
         end else begin
            output_ready = (j.out_hold == 0);
            out_wait = 0;
         end

         if (input_valid && input_ready && j.nw > 0) begin
            checks++;
            if (input_addr !== j.ib + 32'(in_hs % j.nw))
               $display("FAIL input_addr: got %h need %h", input_addr, j.ib + 32'(in_hs % j.nw));
            else passes++;
            in_hs++;
         end
         if (weight_valid && weight_ready) begin
            checks++;
            if (weight_addr !== j.wb + 32'(wt_hs))
               $display("FAIL weight_addr: got %h need %h", weight_addr, j.wb + 32'(wt_hs));
            else passes++;
            wt_hs++;
         end
         if (output_valid && output_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL write_unexpected: addr=%h data=%h with empty queue", output_addr, output_data);
            end else begin
               e = exp_q.pop_front();
               if (output_addr !== e.addr || output_data !== e.data)
                  $display("FAIL write_value: got addr=%h data=%h need addr=%h data=%h",
                           output_addr, output_data, e.addr, e.data);
               else passes++;
            end
            r_last = output_data;
            r_writes++;
         end

         pv_i = input_valid;  pr_i = input_ready;  pa_i = input_addr;
         pv_w = weight_valid; pr_w = weight_ready; pa_w = weight_addr;
         pv_o = output_valid; pr_o = output_ready; pa_o = output_addr; pd_o = output_data;
         @(negedge clk);
      end

      start = 1'b0; irq_clear = 1'b0;
      input_ready = 1'b1; weight_ready = 1'b1; output_ready = 1'b1;

      checks++;
      if (!fin) $display("FAIL job_timeout: job did not finish within 2000 cycles");
      else passes++;
      if (!aborted) begin
         checks++;
         if (exp_q.size() != 0) begin
            $display("FAIL writes_missing: %0d expected writes never seen", exp_q.size());
            exp_q.delete();
         end else passes++;
      end
   endtask

   task automatic pulse_irq_clear();
      irq_clear = 1'b1;
      @(negedge clk);
      irq_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; irq_clear = 1'b0; operation_type = '0;
      in_words = '0; out_count = '0; shift = '0;
      input_base = '0; weight_base = '0; output_base = '0;
      input_ready = 1'b1; weight_ready = 1'b1; output_ready = 1'b1;
      for (int a = 0; a < 256; a++) begin
         in_mem[a] = '0;
         wt_mem[a] = '0;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, busy, error, cycle_count, operation_count, interrupt, input_addr,
           input_valid, weight_addr, weight_valid, output_addr, output_data, output_valid} !== '0)
         $display("FAIL reset_state: busy=%b done=%b irq=%b cyc=%0d ops=%0d",
                  busy, done, interrupt, cycle_count, operation_count);
      else passes++;
      reset = 1'b0;
   endtask

   task automatic test_basic_dense();
      job_t j;
      in_mem[8'h10] = 32'h01010101; in_mem[8'h11] = 32'h01010101;
      wt_mem[8'h20] = 32'h02020202; wt_mem[8'h21] = 32'h02020202;
      j = mk_job(2, 1, 0, 0, 32'h10, 32'h20, 32'h40);
      run_job(j);
      checks++; if (r_last !== 8'd16) $display("FAIL basic_data: got %0d need 16", r_last); else passes++;
      checks++; if (r_done_at !== 7) $display("FAIL basic_done_cycle: got %0d need 7", r_done_at); else passes++;
      checks++; if (cycle_count !== 32'd7) $display("FAIL basic_cycle_count: got %0d need 7", cycle_count); else passes++;
      checks++; if (r_dones !== 1) $display("FAIL basic_done_pulses: got %0d need 1", r_dones); else passes++;
      checks++; if (operation_count !== 32'd8) $display("FAIL basic_op_count: got %0d need 8", operation_count); else passes++;
      checks++; if (interrupt !== 1'b1 || error !== 1'b0)
         $display("FAIL basic_flags: irq=%b err=%b need irq=1 err=0", interrupt, error); else passes++;
      pulse_irq_clear();
      checks++; if (interrupt !== 1'b0) $display("FAIL irq_clear: got %b need 0", interrupt); else passes++;
   endtask

   task automatic test_post_process();
      job_t j;
      in_mem[8'h30] = {8'h00, 8'h9C, 8'h9C, 8'h9C};   // three lanes of -100
      wt_mem[8'h31] = 32'h01010101;
      in_mem[8'h32] = 32'h00000064;                   // 100
      wt_mem[8'h33] = 32'h0000000A;                   // 10
      j = mk_job(1, 1, 0, 1, 32'h30, 32'h31, 32'h50);
      run_job(j);
      checks++; if (r_last !== 8'h00) $display("FAIL relu_neg: got %h need 00", r_last); else passes++;
      j = mk_job(1, 1, 0, 0, 32'h30, 32'h31, 32'h51);
      run_job(j);
      checks++; if (r_last !== 8'h80) $display("FAIL sat_neg: got %h need 80", r_last); else passes++;
      j = mk_job(1, 1, 2, 0, 32'h32, 32'h33, 32'h52);
      run_job(j);
      checks++; if (r_last !== 8'h7F) $display("FAIL sat_pos: got %h need 7f", r_last); else passes++;
   endtask

   task automatic test_stalls();
      job_t j;
      int   base_cycles;
      for (int a = 128; a < 256; a++) begin
         in_mem[a] = BW'($urandom);
         wt_mem[a] = BW'($urandom);
      end
      j = mk_job(3, 4, 9, 0, 32'h80, 32'h90, 32'h200);
      run_job(j);
      base_cycles = int'(cycle_count);
      checks++; if (cycle_count !== 32'd33) $display("FAIL nostall_cycles: got %0d need 33", cycle_count); else passes++;
      j.stall_pct = 40;
      j.out_hold  = 5;
      run_job(j);
      checks++; if (cycle_count !== 32'(r_cyc)) $display("FAIL stall_cycle_count: got %0d need %0d", cycle_count, r_cyc); else passes++;
      checks++; if (int'(cycle_count) < base_cycles + 20)
         $display("FAIL stall_growth: got %0d need at least %0d", cycle_count, base_cycles + 20); else passes++;
      checks++; if (operation_count !== 32'd48) $display("FAIL stall_op_count: got %0d need 48", operation_count); else passes++;
   endtask

   task automatic test_invalid_and_empty();
      job_t j;
      pulse_irq_clear();
      j = mk_job(2, 2, 0, 7, 32'h80, 32'h90, 32'h300);
      run_job(j);
      checks++; if (error !== 1'b1) $display("FAIL invalid_error: got %b need 1", error); else passes++;
      checks++; if (r_dones !== 1) $display("FAIL invalid_done: got %0d pulses need 1", r_dones); else passes++;
      checks++; if (interrupt !== 1'b1) $display("FAIL invalid_irq: got %b need 1", interrupt); else passes++;
      checks++; if (r_valids !== 0) $display("FAIL invalid_access: %0d cycles with valid, need 0", r_valids); else passes++;
      checks++; if (r_cyc !== 1) $display("FAIL invalid_busy: got %0d busy cycles need 1", r_cyc); else passes++;
      pulse_irq_clear();
      j = mk_job(0, 2, 0, 0, 32'h80, 32'h90, 32'h300);
      run_job(j);
      checks++; if (r_dones !== 1) $display("FAIL empty_done: got %0d pulses need 1", r_dones); else passes++;
      checks++; if (operation_count !== 32'd0) $display("FAIL empty_op_count: got %0d need 0", operation_count); else passes++;
      checks++; if (error !== 1'b0) $display("FAIL empty_error: got %b need 0", error); else passes++;
      checks++; if (r_valids !== 0) $display("FAIL empty_access: %0d cycles with valid, need 0", r_valids); else passes++;
   endtask

   task automatic test_busy_start_and_irq();
      job_t j;
      pulse_irq_clear();
      j = mk_job(2, 3, 2, 0, 32'h84, 32'hB0, 32'h400);
      j.restart_at    = 4;
      j.irq_at_finish = 1'b1;
      run_job(j);
      checks++; if (error !== 1'b0) $display("FAIL busy_start_error: got %b need 0", error); else passes++;
      checks++; if (operation_count !== 32'd24) $display("FAIL busy_start_ops: got %0d need 24", operation_count); else passes++;
      checks++; if (r_dones !== 1) $display("FAIL busy_start_done: got %0d pulses need 1", r_dones); else passes++;
      checks++; if (interrupt !== 1'b1) $display("FAIL irq_set_wins: got %b need 1", interrupt); else passes++;
   endtask

   task automatic test_reset_mid_job();
      job_t j;
      j = mk_job(2, 8, 8, 0, 32'h80, 32'hA0, 32'h500);
      j.abort_at = 3;
      run_job(j);
      @(negedge clk);
      reset = 1'b0;
      j.abort_at = -1;
      run_job(j);
      checks++; if (r_writes !== 8) $display("FAIL after_reset_writes: got %0d need 8", r_writes); else passes++;
      checks++; if (operation_count !== 32'd64) $display("FAIL after_reset_ops: got %0d need 64", operation_count); else passes++;
      checks++; if (cycle_count !== 32'd49) $display("FAIL after_reset_cycles: got %0d need 49", cycle_count); else passes++;
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_basic_dense();
      test_post_process();
      test_stalls();
      test_invalid_and_empty();
      test_busy_start_and_irq();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
